// File: rtl/char_window_buff_if.sv
// Bus bundle between char_window_buff and its neighbours: the command parser
// side (proc_*), the target digest, and the MD5 core side (win_*, md5_*).
// Modports:
//   slave  - the window buffer (consumes the stream and digests, offers windows)
//   master - the surrounding system / testbench
interface char_window_buff_if #(
  parameter int unsigned STR_LEN = 19
);
  localparam int unsigned WIN_W = 8 * STR_LEN;

  logic              proc_start;
  logic [15:0]       proc_num_bytes;
  logic [7:0]        proc_data;
  logic              proc_data_valid;
  logic              proc_match_char_next;
  logic [127:0]      target_hash;
  logic              proc_done;
  logic              proc_match;
  logic [15:0]       proc_byte_pos;
  logic [7:0]        proc_match_char;
  logic              win_valid;
  logic              win_ready;
  logic [WIN_W-1:0]  win_data;
  logic              md5_done;
  logic [127:0]      md5_digest;

  modport slave (
    input  proc_start, proc_num_bytes, proc_data, proc_data_valid,
           proc_match_char_next, target_hash, win_ready, md5_done, md5_digest,
    output proc_done, proc_match, proc_byte_pos, proc_match_char,
           win_valid, win_data
  );

  modport master (
    output proc_start, proc_num_bytes, proc_data, proc_data_valid,
           proc_match_char_next, target_hash, win_ready, md5_done, md5_digest,
    input  proc_done, proc_match, proc_byte_pos, proc_match_char,
           win_valid, win_data
  );
endinterface

// File: rtl/char_window_buff.sv
// Character buffer between the command parser and the MD5 core.
// Stores one job's byte stream, offers every STR_LEN-byte sliding window to
// the hasher (one in flight), compares each digest against target_hash and
// reports done/match/position. In DONE the matched string can be replayed
// one byte at a time.
// Ports:
//   clk_96mhz - system clock
//   reset_n   - asynchronous active-low reset
//   bus       - char_window_buff_if.slave (parser stream, window/digest handshake,
//               results and replay byte)
module char_window_buff #(
  parameter int unsigned STR_LEN   = 19,
  parameter int unsigned BUF_DEPTH = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk_96mhz,
  input  logic              reset_n,
  char_window_buff_if.slave bus
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned WIN_W = 8 * STR_LEN;
  localparam int unsigned CNT_W = $clog2(STR_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_FILL, S_ISSUE, S_WAIT_HASH, S_DONE
  } state_t;

  logic [7:0]        mem [BUF_DEPTH];
  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  wr_cnt;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] ridx;
  logic [CNT_W-1:0]  iss_cnt;
  logic [CNT_W-1:0]  got_cnt;
  logic              rd_pend;
  logic [7:0]        rd_data;

  logic [LEN_W-1:0]  new_len_c;
  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [LEN_W-1:0]  fill_addr_c;
  logic              fill_rd_c;
  logic              rd_en_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic              last_pos_c;

  // Job length clamped to the buffer depth.
  assign new_len_c = (bus.proc_num_bytes > 16'(BUF_DEPTH)) ? LEN_W'(BUF_DEPTH)
                                                            : LEN_W'(bus.proc_num_bytes);

  // A byte arriving with proc_start is the first byte of the new job.
  assign wr_en_c   = bus.proc_data_valid &&
                     (bus.proc_start ? (new_len_c != '0) : (wr_cnt < len));
  assign wr_addr_c = bus.proc_start ? '0 : ADDR_W'(wr_cnt);

  // FILL only reads addresses already written; otherwise it stalls.
  assign fill_addr_c = LEN_W'(pos) + LEN_W'(iss_cnt);
  assign fill_rd_c   = (state == S_FILL) && !bus.proc_start &&
                       (iss_cnt < CNT_W'(STR_LEN)) && (fill_addr_c < wr_cnt);

  // Single read port shared by window fill and replay.
  assign rd_en_c   = fill_rd_c || (state == S_DONE);
  assign rd_addr_c = (state == S_DONE) ? (bus.proc_byte_pos[ADDR_W-1:0] + ridx)
                                       : fill_addr_c[ADDR_W-1:0];

  assign last_pos_c = (LEN_W'(pos) == (len - LEN_W'(STR_LEN)));

  // Byte storage write port (contents are not reset).
  always_ff @(posedge clk_96mhz) begin
    if (wr_en_c) mem[wr_addr_c] <= bus.proc_data;
  end

  // Synchronous read, one cycle latency; also the replay output register.
  always_ff @(posedge clk_96mhz or negedge reset_n) begin
    if (!reset_n)     rd_data <= '0;
    else if (rd_en_c) rd_data <= mem[rd_addr_c];
  end

  assign bus.proc_match_char = rd_data;

  // Job control, window assembly and result reporting.
  always_ff @(posedge clk_96mhz or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      len               <= '0;
      wr_cnt            <= '0;
      pos               <= '0;
      ridx              <= '0;
      iss_cnt           <= '0;
      got_cnt           <= '0;
      rd_pend           <= 1'b0;
      bus.proc_done     <= 1'b0;
      bus.proc_match    <= 1'b0;
      bus.proc_byte_pos <= '0;
      bus.win_valid     <= 1'b0;
      bus.win_data      <= '0;
    end else begin
      if (bus.proc_start)  wr_cnt <= wr_en_c ? LEN_W'(1) : '0;
      else if (wr_en_c)    wr_cnt <= wr_cnt + LEN_W'(1);

      rd_pend <= fill_rd_c;

      if (bus.proc_start) begin
        len            <= new_len_c;
        pos            <= '0;
        ridx           <= '0;
        iss_cnt        <= '0;
        got_cnt        <= '0;
        bus.proc_done  <= 1'b0;
        bus.proc_match <= 1'b0;
        bus.win_valid  <= 1'b0;
        state          <= (new_len_c < LEN_W'(STR_LEN)) ? S_WAIT_DATA : S_FILL;
      end else begin
        case (state)
          S_WAIT_DATA: begin
            if (wr_cnt == len) begin
              bus.proc_done  <= 1'b1;
              bus.proc_match <= 1'b0;
              ridx           <= '0;
              state          <= S_DONE;
            end
          end
          S_FILL: begin
            if (fill_rd_c) iss_cnt <= iss_cnt + CNT_W'(1);
            // Returned bytes enter at the LSB end so the first byte ends up in the MSBs.
            if (rd_pend) begin
              bus.win_data <= {bus.win_data[WIN_W-9:0], rd_data};
              if (got_cnt == CNT_W'(STR_LEN - 1)) begin
                got_cnt       <= '0;
                iss_cnt       <= '0;
                bus.win_valid <= 1'b1;
                state         <= S_ISSUE;
              end else begin
                got_cnt <= got_cnt + CNT_W'(1);
              end
            end
          end
          S_ISSUE: begin
            if (bus.win_ready) begin
              bus.win_valid <= 1'b0;
              state         <= S_WAIT_HASH;
            end
          end
          S_WAIT_HASH: begin
            if (bus.md5_done) begin
              if (bus.md5_digest == bus.target_hash) begin
                bus.proc_byte_pos <= 16'(pos);
                bus.proc_match    <= 1'b1;
                bus.proc_done     <= 1'b1;
                ridx              <= '0;
                state             <= S_DONE;
              end else if (last_pos_c) begin
                bus.proc_match <= 1'b0;
                bus.proc_done  <= 1'b1;
                ridx           <= '0;
                state          <= S_DONE;
              end else begin
                pos   <= pos + ADDR_W'(1);
                state <= S_FILL;
              end
            end
          end
          S_DONE: begin
            if (bus.proc_match_char_next)
              ridx <= (ridx == ADDR_W'(STR_LEN - 1)) ? '0 : ridx + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_char_window_buff.sv
// Directed bench for char_window_buff: table of jobs plus hand-written
// sequences for stalls, abort with a stale digest, replay and async reset.
module tb_char_window_buff;
  localparam int unsigned STR_LEN = 19;
  localparam int unsigned WW      = 8 * STR_LEN;
  localparam logic [127:0] TARGET = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  logic clk_96mhz = 1'b0;
  logic reset_n;
  always #5 clk_96mhz = ~clk_96mhz;

  char_window_buff_if #(.STR_LEN(STR_LEN)) bus ();

  char_window_buff #(.STR_LEN(STR_LEN), .BUF_DEPTH(1024), .ADDR_W(10)) dut (
    .clk_96mhz (clk_96mhz),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0]    exp_mem [1024];
  logic [WW-1:0] cap_win [64];
  int win_cnt;
  int job_id    = 0;
  int match_idx = -1;
  int hash_lat  = 3;

  typedef struct {
    int len;
    int mi;
    int nwin;
    bit mexp;
    int pexp;
    bit replay;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int i, input int seed);
    return 8'(32'h61 + i + 3 * seed);
  endfunction

  function automatic logic [WW-1:0] exp_win(input int p);
    logic [WW-1:0] w = '0;
    for (int k = 0; k < STR_LEN; k++) w = {w[WW-9:0], exp_mem[p+k]};
    return w;
  endfunction

  task automatic tick();
    @(posedge clk_96mhz);
    #1;
  endtask

  // Pulse proc_start with the first byte, then stream the rest with 'gap' idle cycles between.
  task automatic start_job(input int len, input int seed, input int gap, input int nsend);
    for (int i = 0; i < 1024; i++) exp_mem[i] = byte_of(i, seed);
    job_id++;
    bus.proc_start      = 1'b1;
    bus.proc_num_bytes  = 16'(len);
    bus.proc_data       = byte_of(0, seed);
    bus.proc_data_valid = (nsend > 0);
    tick();
    bus.proc_start = 1'b0;
    for (int i = 1; i < nsend; i++) begin
      if (gap > 0) begin
        bus.proc_data_valid = 1'b0;
        repeat (gap) tick();
      end
      bus.proc_data       = byte_of(i, seed);
      bus.proc_data_valid = 1'b1;
      tick();
    end
    bus.proc_data_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (!bus.proc_done && c < 3000) begin
      tick();
      c++;
    end
    chk({name, "_done"}, WW'(bus.proc_done), WW'(1));
  endtask

  // Hasher model: one window at a time, digest equals TARGET only for window match_idx.
  initial begin
    int seen;
    int idx;
    logic [127:0] dig;
    bus.md5_done   = 1'b0;
    bus.md5_digest = '0;
    win_cnt = 0;
    seen    = 0;
    forever begin
      @(negedge clk_96mhz);
      if (job_id != seen) begin
        seen    = job_id;
        win_cnt = 0;
      end
      if (bus.win_valid && bus.win_ready) begin
        idx = win_cnt;
        if (idx < 64) cap_win[idx] = bus.win_data;
        win_cnt++;
        dig = (idx == match_idx) ? TARGET : ~TARGET;
        @(posedge clk_96mhz);
        repeat (hash_lat) @(posedge clk_96mhz);
        #1;
        bus.md5_done   = 1'b1;
        bus.md5_digest = dig;
        @(posedge clk_96mhz);
        #1;
        bus.md5_done   = 1'b0;
        bus.md5_digest = '0;
      end
    end
  end

  initial begin
    logic [WW-1:0] held;
    int c;

    vt[0] = '{len: 19, mi: 0,  nwin: 1, mexp: 1'b1, pexp: 0, replay: 1'b0};
    vt[1] = '{len: 40, mi: 7,  nwin: 8, mexp: 1'b1, pexp: 7, replay: 1'b1};
    vt[2] = '{len: 25, mi: -1, nwin: 7, mexp: 1'b0, pexp: 0, replay: 1'b0};
    vt[3] = '{len: 10, mi: -1, nwin: 0, mexp: 1'b0, pexp: 0, replay: 1'b0};
    vt[4] = '{len: 20, mi: 1,  nwin: 2, mexp: 1'b1, pexp: 1, replay: 1'b0};
    vt[5] = '{len: 0,  mi: -1, nwin: 0, mexp: 1'b0, pexp: 0, replay: 1'b0};

    bus.proc_start           = 1'b0;
    bus.proc_num_bytes       = '0;
    bus.proc_data            = '0;
    bus.proc_data_valid      = 1'b0;
    bus.proc_match_char_next = 1'b0;
    bus.target_hash          = TARGET;
    bus.win_ready            = 1'b1;
    reset_n                  = 1'b0;

    #2;
    chk("rst_done",     WW'(bus.proc_done),     '0);
    chk("rst_match",    WW'(bus.proc_match),    '0);
    chk("rst_valid",    WW'(bus.win_valid),     '0);
    chk("rst_win_data", bus.win_data,           '0);
    chk("rst_byte_pos", WW'(bus.proc_byte_pos), '0);
    repeat (3) @(posedge clk_96mhz);
    #1;
    reset_n = 1'b1;
    tick();

    // Table-driven jobs.
    for (int v = 0; v < 6; v++) begin
      match_idx = vt[v].mi;
      start_job(vt[v].len, v, 0, vt[v].len);
      if (vt[v].nwin == 0) begin
        chk($sformatf("v%0d_early_done", v), WW'(bus.proc_done), '0);
        tick();
        chk($sformatf("v%0d_done_next", v), WW'(bus.proc_done), WW'(1));
      end
      wait_done($sformatf("v%0d", v));
      chk($sformatf("v%0d_match", v), WW'(bus.proc_match), WW'(vt[v].mexp));
      if (vt[v].mexp)
        chk($sformatf("v%0d_pos", v), WW'(bus.proc_byte_pos), WW'(vt[v].pexp));
      chk($sformatf("v%0d_nwin", v), WW'(win_cnt), WW'(vt[v].nwin));
      chk($sformatf("v%0d_valid_low", v), WW'(bus.win_valid), '0);
      for (int i = 0; i < vt[v].nwin; i++)
        chk($sformatf("v%0d_win%0d", v, i), cap_win[i], exp_win(i));
      if (vt[v].replay) begin
        tick();
        chk("replay_0", WW'(bus.proc_match_char), WW'(exp_mem[vt[v].pexp]));
        for (int j = 1; j <= STR_LEN; j++) begin
          bus.proc_match_char_next = 1'b1;
          tick();
          bus.proc_match_char_next = 1'b0;
          tick();
          chk($sformatf("replay_%0d", j), WW'(bus.proc_match_char),
              WW'(exp_mem[vt[v].pexp + (j % STR_LEN)]));
        end
      end
    end

    // Slow byte stream with the hasher back-pressuring.
    match_idx     = 0;
    bus.win_ready = 1'b0;
    start_job(19, 7, 4, 19);
    chk("stall_no_early_valid", WW'(bus.win_valid), '0);
    c = 0;
    while (!bus.win_valid && c < 20) begin
      tick();
      c++;
    end
    chk("stall_valid", WW'(bus.win_valid), WW'(1));
    held = bus.win_data;
    chk("stall_win", held, exp_win(0));
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("stall_hold%0d", k), {bus.win_valid, bus.win_data[WW-2:0]}, {1'b1, held[WW-2:0]});
    end
    bus.win_ready = 1'b1;
    wait_done("stall");
    chk("stall_match", WW'(bus.proc_match), WW'(1));
    chk("stall_nwin", WW'(win_cnt), WW'(1));

    // Abort while a digest is pending; the late digest equals the target.
    match_idx = 0;
    hash_lat  = 10;
    start_job(40, 8, 0, 19);
    c = 0;
    while (win_cnt < 1 && c < 100) begin
      tick();
      c++;
    end
    chk("abort_first_win", WW'(win_cnt), WW'(1));
    tick();
    start_job(19, 9, 0, 19);
    chk("abort_stale_ignored", WW'(bus.proc_done), '0);
    wait_done("abort");
    chk("abort_match", WW'(bus.proc_match), WW'(1));
    chk("abort_pos", WW'(bus.proc_byte_pos), '0);
    chk("abort_nwin", WW'(win_cnt), WW'(1));
    chk("abort_win", cap_win[0], exp_win(0));
    hash_lat = 3;

    // Asynchronous reset in the middle of FILL.
    start_job(40, 10, 0, 5);
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_done",     WW'(bus.proc_done),       '0);
    chk("arst_match",    WW'(bus.proc_match),      '0);
    chk("arst_valid",    WW'(bus.win_valid),       '0);
    chk("arst_win_data", bus.win_data,             '0);
    chk("arst_char",     WW'(bus.proc_match_char), '0);
    chk("arst_byte_pos", WW'(bus.proc_byte_pos),   '0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
